if_id_queue: RTL and testbench

Instruction queue between the fetch stage and decode. It buffers fetched {instruction, current PC, next PC} packets in a small circular FIFO with valid/ready handshakes on both sides, so fetch can keep running while decode stalls. It accepts a flush from branch/jump resolution and stops accepting packets after a HALT is enqueued. Its output feeds the decode stage directly.

---
 rtl/wisc_pkg.sv | 24 ++
 rtl/if_id_queue_if.sv | 41 ++++
 rtl/fifo_ptr.sv | 43 ++++
 rtl/if_id_queue.sv | 112 +++++++++++
 tb/tb_if_id_queue.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wisc_pkg.sv
// -----------------------------------------------------------------------------
// wisc_pkg
// Shared definitions for the fetch/decode boundary:
//   NOP_INSTR    - instruction presented to decode when nothing is queued
//   HALT_OPCODE  - opcode field [15:11] that identifies a HALT instruction
//   fetch_pkt_t  - {instr, pc_curr, pc_next} packet, 48 bits
//   is_halt()    - opcode test used by the queue's halt detection
// -----------------------------------------------------------------------------
package wisc_pkg;

    localparam logic [15:0] NOP_INSTR   = 16'h0800;
    localparam logic [4:0]  HALT_OPCODE = 5'b00000;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_curr;
        logic [15:0] pc_next;
    } fetch_pkt_t;

    function automatic logic is_halt(input logic [15:0] instr);
        return instr[15:11] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// -----------------------------------------------------------------------------
// if_id_queue_if
// Handshake bundle between fetch, the instruction queue and decode.
//   Fetch side : f_valid, f_instr, f_pc_curr, f_pc_next -> queue; f_ready <- queue
//   Decode side: d_valid, d_instr, d_pc_curr, d_pc_next <- queue; d_ready -> queue
//   Control    : flush -> queue; halted, count <- queue
// modport master : the surrounding pipeline (drives fetch data, d_ready, flush)
// modport slave  : the queue itself
// -----------------------------------------------------------------------------
interface if_id_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          f_valid;
    logic [15:0]   f_instr;
    logic [15:0]   f_pc_curr;
    logic [15:0]   f_pc_next;
    logic          f_ready;

    logic          d_valid;
    logic [15:0]   d_instr;
    logic [15:0]   d_pc_curr;
    logic [15:0]   d_pc_next;
    logic          d_ready;

    logic          flush;
    logic          halted;
    logic [CW-1:0] count;

    modport master (
        output f_valid, f_instr, f_pc_curr, f_pc_next, d_ready, flush,
        input  f_ready, d_valid, d_instr, d_pc_curr, d_pc_next, halted, count
    );

    modport slave (
        input  f_valid, f_instr, f_pc_curr, f_pc_next, d_ready, flush,
        output f_ready, d_valid, d_instr, d_pc_curr, d_pc_next, halted, count
    );

endinterface

// File: rtl/fifo_ptr.sv
// -----------------------------------------------------------------------------
// fifo_ptr
// Wrap-around pointer register (modulo 2**WIDTH).
//   clk   : clock
//   rst   : asynchronous active-low reset, pointer -> 0
//   inc_i : advance pointer by one
//   clr_i : synchronous clear, takes priority over inc_i
//   ptr_o : current pointer value
// -----------------------------------------------------------------------------
module fifo_ptr #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] ptr_o
);

    logic [WIDTH-1:0] ptr_q;
    logic [WIDTH-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            // Natural overflow gives the modulo-DEPTH wrap.
            ptr_d = ptr_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/if_id_queue.sv
// -----------------------------------------------------------------------------
// if_id_queue
// Circular FIFO of fetch packets between fetch and decode.
//   clk : clock, all state updates on the rising edge
//   rst : asynchronous active-low reset
//   q   : if_id_queue_if.slave (fetch handshake, decode handshake,
//         flush, halted, count)
// DEPTH must match the DEPTH of the connected interface (power of two, >= 2).
// f_ready and d_valid depend only on registered state; the decode payload is
// muxed from storage by the read pointer with no enqueue bypass.
// -----------------------------------------------------------------------------
module if_id_queue
    import wisc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    if_id_queue_if.slave q
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          halted_q;
    logic          halted_d;
    fetch_pkt_t    mem_q [DEPTH];

    logic       enq;
    logic       deq;
    logic       full;
    logic       empty;
    fetch_pkt_t head_pkt;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    assign q.f_ready = ~full & ~halted_q;
    assign q.d_valid = ~empty;

    assign enq = q.f_valid & q.f_ready;
    assign deq = q.d_valid & q.d_ready;

    // Flush squashes any concurrent transfer, so pointer moves are gated here
    // and the clear input of each pointer carries the flush itself.
    fifo_ptr #(.WIDTH(PW)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (enq & ~q.flush),
        .clr_i (q.flush),
        .ptr_o (wr_ptr)
    );

    fifo_ptr #(.WIDTH(PW)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (deq & ~q.flush),
        .clr_i (q.flush),
        .ptr_o (rd_ptr)
    );

    always_comb begin
        count_d  = count_q;
        halted_d = halted_q;
        if (q.flush) begin
            count_d  = '0;
            halted_d = 1'b0;
        end else begin
            // Enqueue+dequeue together leaves the occupancy unchanged.
            unique case ({enq, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (enq && is_halt(q.f_instr)) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

    // Payload storage carries no reset; validity lives entirely in count_q.
    always_ff @(posedge clk) begin
        if (enq && !q.flush) begin
            mem_q[wr_ptr] <= '{instr:   q.f_instr,
                               pc_curr: q.f_pc_curr,
                               pc_next: q.f_pc_next};
        end
    end

    assign head_pkt = mem_q[rd_ptr];

    assign q.d_instr   = empty ? NOP_INSTR : head_pkt.instr;
    assign q.d_pc_curr = empty ? 16'h0000  : head_pkt.pc_curr;
    assign q.d_pc_next = empty ? 16'h0000  : head_pkt.pc_next;
    assign q.halted    = halted_q;
    assign q.count     = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// -----------------------------------------------------------------------------
// tb_if_id_queue
// Self-checking bench for if_id_queue (DEPTH=4). A queue-based reference model
// tracks the packets the queue should hold and whether a HALT has been taken.
// -----------------------------------------------------------------------------
module tb_if_id_queue;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_curr;
        logic [15:0] pc_next;
    } tb_pkt_t;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    tb_pkt_t model_q[$];
    logic    model_halted = 1'b0;

    if_id_queue_if #(.DEPTH(4)) bus ();

    if_id_queue #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected observable state: {count, f_ready, d_valid, halted, instr, pc_curr, pc_next}
    function automatic logic [53:0] exp_vec();
        logic [15:0] ei;
        logic [15:0] ec;
        logic [15:0] en;
        if (model_q.size() != 0) begin
            ei = model_q[0].instr;
            ec = model_q[0].pc_curr;
            en = model_q[0].pc_next;
        end else begin
            ei = 16'h0800;
            ec = 16'h0000;
            en = 16'h0000;
        end
        return {3'(model_q.size()), (model_q.size() < 4) && !model_halted,
                model_q.size() != 0, model_halted, ei, ec, en};
    endfunction

    function automatic logic [53:0] dut_vec();
        return {bus.count, bus.f_ready, bus.d_valid, bus.halted,
                bus.d_instr, bus.d_pc_curr, bus.d_pc_next};
    endfunction

    // Drive one cycle of stimulus, let the edge happen, update the model.
    task automatic do_cycle(input logic fv, input logic [15:0] ins,
                            input logic [15:0] pcc, input logic [15:0] pcn,
                            input logic dr, input logic fl);
        logic enq;
        logic deq;
        bus.f_valid   = fv;
        bus.f_instr   = ins;
        bus.f_pc_curr = pcc;
        bus.f_pc_next = pcn;
        bus.d_ready   = dr;
        bus.flush     = fl;
        enq = fv && (model_q.size() < 4) && !model_halted;
        deq = dr && (model_q.size() != 0);
        @(posedge clk);
        #1;
        if (fl) begin
            model_q.delete();
            model_halted = 1'b0;
        end else begin
            if (deq) void'(model_q.pop_front());
            if (enq) begin
                model_q.push_back('{instr: ins, pc_curr: pcc, pc_next: pcn});
                if (ins[15:11] == 5'b00000) model_halted = 1'b1;
            end
        end
        cyc++;
        $display("cyc=%0d fv=%0b instr=%h dr=%0b fl=%0b enq=%0b deq=%0b count=%0d halted=%0b",
                 cyc, fv, ins, dr, fl, enq && !fl, deq && !fl, bus.count, bus.halted);
        bus.f_valid = 1'b0;
        bus.d_ready = 1'b0;
        bus.flush   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.f_valid = 1'b0; bus.f_instr = '0; bus.f_pc_curr = '0; bus.f_pc_next = '0;
        bus.d_ready = 1'b0; bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== {3'd0, 1'b1, 1'b0, 1'b0, 16'h0800, 16'h0000, 16'h0000}) begin
            failures++;
            $display("FAIL reset_state got=%h want=%h", dut_vec(),
                     {3'd0, 1'b1, 1'b0, 1'b0, 16'h0800, 16'h0000, 16'h0000});
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_release got=%h want=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b1, 16'h4001 + 16'(i), 16'(2 * i), 16'(2 * i + 2), 1'b0, 1'b0);
            checks++;
            if (bus.count !== 3'(model_q.size())) begin
                failures++;
                $display("FAIL fill_count[%0d] got=%0d want=%0d", i, bus.count, model_q.size());
            end
        end
        checks++;
        if (bus.count !== 3'd4 || bus.f_ready !== 1'b0 || bus.d_instr !== 16'h4001) begin
            failures++;
            $display("FAIL fill_full got count=%0d f_ready=%0b d_instr=%h want 4 0 4001",
                     bus.count, bus.f_ready, bus.d_instr);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.d_valid !== 1'b1 || bus.d_instr !== 16'h4001 + 16'(i) ||
                bus.d_pc_curr !== 16'(2 * i) || bus.d_pc_next !== 16'(2 * i + 2)) begin
                failures++;
                $display("FAIL drain_order[%0d] got v=%0b instr=%h pc=%h npc=%h want 1 %h %h %h",
                         i, bus.d_valid, bus.d_instr, bus.d_pc_curr, bus.d_pc_next,
                         16'h4001 + 16'(i), 16'(2 * i), 16'(2 * i + 2));
            end
            do_cycle(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
        end
        checks++;
        if (bus.d_valid !== 1'b0 || bus.d_instr !== 16'h0800 ||
            bus.d_pc_curr !== 16'h0000 || bus.d_pc_next !== 16'h0000 || bus.count !== 3'd0) begin
            failures++;
            $display("FAIL drain_empty got v=%0b instr=%h pc=%h npc=%h count=%0d want 0 0800 0 0 0",
                     bus.d_valid, bus.d_instr, bus.d_pc_curr, bus.d_pc_next, bus.count);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] ins;
        for (int i = 0; i < 2; i++)
            do_cycle(1'b1, 16'h5000 + 16'(i), 16'h0100 + 16'(2 * i), 16'h0102 + 16'(2 * i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            ins = {5'($urandom_range(1, 31)), 11'($urandom)};
            do_cycle(1'b1, ins, 16'($urandom), 16'($urandom), 1'b1, 1'b0);
            checks++;
            if (bus.count !== 3'd2 || dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL wrap[%0d] got=%h want=%h", i, dut_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.d_instr !== model_q[0].instr) begin
                failures++;
                $display("FAIL wrap_drain[%0d] got=%h want=%h", i, bus.d_instr, model_q[0].instr);
            end
            do_cycle(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
        end
    endtask

    task automatic test_halt();
        do_cycle(1'b1, 16'h4001, 16'h0020, 16'h0022, 1'b0, 1'b0);
        checks++;
        if (bus.halted !== 1'b0 || bus.f_ready !== 1'b1) begin
            failures++;
            $display("FAIL halt_before got halted=%0b f_ready=%0b want 0 1", bus.halted, bus.f_ready);
        end
        do_cycle(1'b1, 16'h0000, 16'h0022, 16'h0022, 1'b0, 1'b0);
        checks++;
        if (bus.halted !== 1'b1 || bus.f_ready !== 1'b0) begin
            failures++;
            $display("FAIL halt_set got halted=%0b f_ready=%0b want 1 0", bus.halted, bus.f_ready);
        end
        do_cycle(1'b1, 16'h4002, 16'h0024, 16'h0026, 1'b0, 1'b0);
        checks++;
        if (bus.count !== 3'd2) begin
            failures++;
            $display("FAIL halt_refuse got count=%0d want 2", bus.count);
        end
        checks++;
        if (bus.d_instr !== 16'h4001) begin
            failures++;
            $display("FAIL halt_drain0 got=%h want=4001", bus.d_instr);
        end
        do_cycle(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
        checks++;
        if (bus.d_instr !== 16'h0000 || bus.d_valid !== 1'b1) begin
            failures++;
            $display("FAIL halt_drain1 got instr=%h v=%0b want 0000 1", bus.d_instr, bus.d_valid);
        end
        do_cycle(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
        checks++;
        if (bus.d_valid !== 1'b0 || bus.halted !== 1'b1 || bus.f_ready !== 1'b0) begin
            failures++;
            $display("FAIL halt_drained got v=%0b halted=%0b f_ready=%0b want 0 1 0",
                     bus.d_valid, bus.halted, bus.f_ready);
        end
    endtask

    task automatic test_flush();
        // Flush releases the halt; the concurrent enqueue is dropped.
        do_cycle(1'b1, 16'h4003, 16'h0030, 16'h0032, 1'b0, 1'b1);
        checks++;
        if (bus.halted !== 1'b0 || bus.f_ready !== 1'b1 || bus.count !== 3'd0) begin
            failures++;
            $display("FAIL flush_unhalt got halted=%0b f_ready=%0b count=%0d want 0 1 0",
                     bus.halted, bus.f_ready, bus.count);
        end
        for (int i = 0; i < 3; i++)
            do_cycle(1'b1, 16'h4010 + 16'(i), 16'h0040 + 16'(2 * i), 16'h0042 + 16'(2 * i), 1'b0, 1'b0);
        checks++;
        if (bus.count !== 3'd3) begin
            failures++;
            $display("FAIL flush_setup got count=%0d want 3", bus.count);
        end
        do_cycle(1'b1, 16'h4099, 16'h0050, 16'h0052, 1'b1, 1'b1);
        checks++;
        if (bus.count !== 3'd0 || bus.d_valid !== 1'b0 || bus.f_ready !== 1'b1 ||
            bus.halted !== 1'b0 || bus.d_instr !== 16'h0800) begin
            failures++;
            $display("FAIL flush_priority got count=%0d v=%0b f_ready=%0b halted=%0b instr=%h want 0 0 1 0 0800",
                     bus.count, bus.d_valid, bus.f_ready, bus.halted, bus.d_instr);
        end
        do_cycle(1'b1, 16'h4020, 16'h0200, 16'h0202, 1'b0, 1'b0);
        checks++;
        if (bus.d_instr !== 16'h4020 || bus.d_pc_curr !== 16'h0200 || bus.count !== 3'd1) begin
            failures++;
            $display("FAIL flush_redirect got instr=%h pc=%h count=%0d want 4020 0200 1",
                     bus.d_instr, bus.d_pc_curr, bus.count);
        end
        do_cycle(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++)
            do_cycle(1'b1, 16'h4030 + 16'(i), 16'h0300 + 16'(2 * i), 16'h0302 + 16'(2 * i), 1'b0, 1'b0);
        checks++;
        if (bus.count !== 3'd2) begin
            failures++;
            $display("FAIL async_setup got count=%0d want 2", bus.count);
        end
        // Mid-cycle: the next rising edge is still several time units away.
        #2;
        rst = 1'b0;
        #1;
        model_q.delete();
        model_halted = 1'b0;
        checks++;
        if (dut_vec() !== {3'd0, 1'b1, 1'b0, 1'b0, 16'h0800, 16'h0000, 16'h0000}) begin
            failures++;
            $display("FAIL async_reset got=%h want=%h", dut_vec(),
                     {3'd0, 1'b1, 1'b0, 1'b0, 16'h0800, 16'h0000, 16'h0000});
        end
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        $display("async reset applied and released at t=%0t", $time);
    endtask

    task automatic test_random();
        logic        fv;
        logic        dr;
        logic        fl;
        logic [15:0] ins;
        for (int i = 0; i < 200; i++) begin
            fv  = ($urandom_range(0, 3) != 0);
            dr  = ($urandom_range(0, 4) < 3);
            fl  = ($urandom_range(0, 19) == 0);
            ins = ($urandom_range(0, 9) == 0) ? {5'b00000, 11'($urandom)}
                                               : {5'($urandom_range(1, 31)), 11'($urandom)};
            do_cycle(fv, ins, 16'($urandom), 16'($urandom), dr, fl);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random[%0d] got=%h want=%h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_halt();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
